// File: rtl/jogo_pkg.sv
// jogo_pkg: shared state codes, map geometry and helpers for the shooting game
package jogo_pkg;
  localparam int LINHAS = 5;
  localparam int COLUNAS = 7;
  typedef enum logic [2:0] {
    OCIOSO = 3'd0, CONTAGEM = 3'd1, JOGANDO = 3'd2, AVALIA = 3'd3, VITORIA = 3'd4, DERROTA = 3'd5
  } estado_t;
  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 7; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction
  function automatic logic coord_valida(input logic [2:0] l, input logic [2:0] c);
    return (l < 3'(LINHAS)) && (c < 3'(COLUNAS));
  endfunction
endpackage

// File: rtl/detector_borda.sv
// detector_borda: registered rising-edge detector for a debounced level input
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic sinal,
  output logic borda
);
  logic sinal_q;
  always_ff @(posedge clk) sinal_q <= reset ? 1'b0 : sinal;
  assign borda = sinal & ~sinal_q;
endmodule

// File: rtl/controle_disparo.sv
// controle_disparo: shooting phase of the 5x7 naval game (ship count, shot scoring, win/lose)
module controle_disparo
  import jogo_pkg::*;
#(
  parameter int MAX_ERROS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       disparar,
  input  logic [2:0] linha,
  input  logic [2:0] coluna,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  output logic [6:0] acerto0,
  output logic [6:0] acerto1,
  output logic [6:0] acerto2,
  output logic [6:0] acerto3,
  output logic [6:0] acerto4,
  output logic [6:0] erro0,
  output logic [6:0] erro1,
  output logic [6:0] erro2,
  output logic [6:0] erro3,
  output logic [6:0] erro4,
  output logic [5:0] restantes,
  output logic [3:0] erros,
  output logic [2:0] estado,
  output logic       pulso_acerto,
  output logic       pulso_erro,
  output logic       pulso_invalido,
  output logic       venceu,
  output logic       perdeu
);
  estado_t est, prox;
  logic [LINHAS-1:0][COLUNAS-1:0] snap, acerto, erro;
  logic [2:0] idx, lin_r, col_r;
  logic borda, invalido, alvo;
  detector_borda u_borda (.clk(clk), .reset(reset), .sinal(disparar), .borda(borda));
  // out-of-range coordinates short-circuit before the matrix bits matter
  assign invalido = !coord_valida(lin_r, col_r) || acerto[lin_r][col_r] || erro[lin_r][col_r];
  assign alvo = snap[lin_r][col_r];
  always_comb begin
    prox = est;
    if (iniciar) prox = CONTAGEM;
    else if (est == CONTAGEM && idx == 3'(LINHAS - 1))
      prox = (restantes + 6'(popcount7(snap[idx])) == 6'd0) ? VITORIA : JOGANDO;
    else if (est == JOGANDO && borda) prox = AVALIA;
    else if (est == AVALIA)
      prox = invalido ? JOGANDO :
             alvo ? ((restantes == 6'd1) ? VITORIA : JOGANDO) :
             ((erros == 4'(MAX_ERROS - 1)) ? DERROTA : JOGANDO);
  end
  always_ff @(posedge clk) est <= reset ? OCIOSO : prox;
  always_ff @(posedge clk) begin
    if (reset) begin
      snap <= '0;
      acerto <= '0;
      erro <= '0;
      restantes <= '0;
      erros <= '0;
      idx <= '0;
      lin_r <= '0;
      col_r <= '0;
      pulso_acerto <= 1'b0;
      pulso_erro <= 1'b0;
      pulso_invalido <= 1'b0;
    end else begin
      pulso_acerto <= 1'b0;
      pulso_erro <= 1'b0;
      pulso_invalido <= 1'b0;
      if (iniciar) begin
        snap <= {mapa4, mapa3, mapa2, mapa1, mapa0};
        acerto <= '0;
        erro <= '0;
        restantes <= '0;
        erros <= '0;
        idx <= '0;
      end else if (est == CONTAGEM) begin
        restantes <= restantes + 6'(popcount7(snap[idx]));
        idx <= idx + 3'd1;
      end else if (est == JOGANDO && borda) begin
        lin_r <= linha;
        col_r <= coluna;
      end else if (est == AVALIA) begin
        if (invalido) pulso_invalido <= 1'b1;
        else if (alvo) begin
          acerto[lin_r][col_r] <= 1'b1;
          restantes <= restantes - 6'd1;
          pulso_acerto <= 1'b1;
        end else begin
          erro[lin_r][col_r] <= 1'b1;
          erros <= erros + 4'd1;
          pulso_erro <= 1'b1;
        end
      end
    end
  end
  assign estado = est;
  assign venceu = (est == VITORIA);
  assign perdeu = (est == DERROTA);
  assign {acerto4, acerto3, acerto2, acerto1, acerto0} = acerto;
  assign {erro4, erro3, erro2, erro1, erro0} = erro;
endmodule

// File: tb/tb_controle_disparo.sv
// tb_controle_disparo: directed + random game sequences against a cell-level game model
module tb_controle_disparo;
  localparam int MAXE = 5;
  localparam int S_OCI = 0, S_CNT = 1, S_JOG = 2, S_AVA = 3, S_VIT = 4, S_DER = 5;
  logic clk = 1'b0;
  logic reset = 1'b1, iniciar = 1'b0, disparar = 1'b0;
  logic [2:0] linha = '0, coluna = '0;
  logic [6:0] mapa [5];
  logic [6:0] acerto [5];
  logic [6:0] erro [5];
  logic [5:0] restantes;
  logic [3:0] erros;
  logic [2:0] estado;
  logic pulso_acerto, pulso_erro, pulso_invalido, venceu, perdeu;
  int checks = 0, errors = 0;
  int m_map [5][7];
  bit m_hit [5][7];
  bit m_miss [5][7];
  int m_rem, m_err, m_st;
  bit e_pa, e_pe, e_pi;

  controle_disparo #(.MAX_ERROS(MAXE)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .disparar(disparar),
    .linha(linha), .coluna(coluna),
    .mapa0(mapa[0]), .mapa1(mapa[1]), .mapa2(mapa[2]), .mapa3(mapa[3]), .mapa4(mapa[4]),
    .acerto0(acerto[0]), .acerto1(acerto[1]), .acerto2(acerto[2]), .acerto3(acerto[3]), .acerto4(acerto[4]),
    .erro0(erro[0]), .erro1(erro[1]), .erro2(erro[2]), .erro3(erro[3]), .erro4(erro[4]),
    .restantes(restantes), .erros(erros), .estado(estado),
    .pulso_acerto(pulso_acerto), .pulso_erro(pulso_erro), .pulso_invalido(pulso_invalido),
    .venceu(venceu), .perdeu(perdeu)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [34:0] ea, ee, da, de;
    ea = '0;
    ee = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 7; j++) begin
        ea[i*7+j] = m_hit[i][j];
        ee[i*7+j] = m_miss[i][j];
      end
    da = {acerto[4], acerto[3], acerto[2], acerto[1], acerto[0]};
    de = {erro[4], erro[3], erro[2], erro[1], erro[0]};
    chk({tag, "/estado"}, 64'(estado), 64'(m_st));
    chk({tag, "/restantes"}, 64'(restantes), 64'(m_rem));
    chk({tag, "/erros"}, 64'(erros), 64'(m_err));
    chk({tag, "/acerto"}, 64'(da), 64'(ea));
    chk({tag, "/erro"}, 64'(de), 64'(ee));
    chk({tag, "/venceu"}, 64'(venceu), 64'(m_st == S_VIT));
    chk({tag, "/perdeu"}, 64'(perdeu), 64'(m_st == S_DER));
    chk({tag, "/pulso_acerto"}, 64'(pulso_acerto), 64'(e_pa));
    chk({tag, "/pulso_erro"}, 64'(pulso_erro), 64'(e_pe));
    chk({tag, "/pulso_invalido"}, 64'(pulso_invalido), 64'(e_pi));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 7; j++) begin
        m_map[i][j] = 0;
        m_hit[i][j] = 1'b0;
        m_miss[i][j] = 1'b0;
      end
    m_rem = 0;
    m_err = 0;
    m_st = S_OCI;
    e_pa = 1'b0;
    e_pe = 1'b0;
    e_pi = 1'b0;
  endtask

  task automatic set_map(input logic [6:0] r0, r1, r2, r3, r4);
    mapa[0] = r0; mapa[1] = r1; mapa[2] = r2; mapa[3] = r3; mapa[4] = r4;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    model_clear();
    chk_all("reset");
    reset = 1'b0;
  endtask

  task automatic start_game();
    int part;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 7; j++) m_map[i][j] = int'(mapa[i][j]);
    for (int i = 0; i < 5; i++) mapa[i] = 7'($urandom);
    m_st = S_CNT;
    chk_all("contagem0");
    part = 0;
    for (int r = 0; r < 5; r++) begin
      step();
      for (int j = 0; j < 7; j++) part += m_map[r][j];
      m_rem = part;
      if (r == 4) m_st = (part == 0) ? S_VIT : S_JOG;
      chk_all("contagem");
    end
  endtask

  task automatic apply(input int l, input int c);
    e_pa = 1'b0; e_pe = 1'b0; e_pi = 1'b0;
    if (l > 4 || c > 6) e_pi = 1'b1;
    else if (m_hit[l][c] || m_miss[l][c]) e_pi = 1'b1;
    else if (m_map[l][c] != 0) begin
      m_hit[l][c] = 1'b1;
      m_rem--;
      e_pa = 1'b1;
    end else begin
      m_miss[l][c] = 1'b1;
      m_err++;
      e_pe = 1'b1;
    end
    m_st = (m_rem == 0) ? S_VIT : (m_err == MAXE) ? S_DER : S_JOG;
  endtask

  task automatic fire(input int l, input int c);
    linha = 3'(l);
    coluna = 3'(c);
    disparar = 1'b1;
    step();
    e_pa = 1'b0; e_pe = 1'b0; e_pi = 1'b0;
    if (m_st == S_JOG) begin
      m_st = S_AVA;
      chk_all("avalia");
      step();
      apply(l, c);
      chk_all("resultado");
    end else begin
      chk_all("ignorado");
      step();
      chk_all("ignorado2");
    end
    disparar = 1'b0;
    step();
    e_pa = 1'b0; e_pe = 1'b0; e_pi = 1'b0;
    chk_all("pos_disparo");
  endtask

  initial begin
    int l, c, n;
    bit found;
    for (int i = 0; i < 5; i++) mapa[i] = '0;
    step();
    step();
    reset = 1'b0;
    model_clear();
    chk_all("reset_inicial");
    fire(0, 2);
    set_map(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
    start_game();
    chk("total_navios", 64'(restantes), 64'd13);
    fire(0, 2);
    fire(0, 2);
    fire(0, 0); fire(0, 1); fire(0, 3); fire(0, 4); fire(0, 5);
    chk("derrota_perdeu", 64'(perdeu), 64'd1);
    chk("derrota_erro0", 64'(erro[0]), 64'b0111011);
    fire(1, 1);
    set_map(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
    start_game();
    fire(5, 0);
    fire(1, 7);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 7; j++)
        if (m_map[i][j] != 0) fire(i, j);
    chk("vitoria_venceu", 64'(venceu), 64'd1);
    fire(0, 0);
    set_map('0, '0, '0, '0, '0);
    start_game();
    set_map(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step();
    step();
    do_reset();
    set_map(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
    start_game();
    linha = 3'd0;
    coluna = 3'd2;
    disparar = 1'b1;
    step();
    m_st = S_AVA;
    chk_all("avalia_antes_reset");
    disparar = 1'b0;
    do_reset();
    set_map(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
    start_game();
    fire(0, 2);
    set_map(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
    linha = 3'd0;
    coluna = 3'd0;
    disparar = 1'b1;
    start_game();
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all("segurado_apos_inicio");
    end
    disparar = 1'b0;
    step();
    chk_all("solto");
    linha = 3'd1;
    coluna = 3'd2;
    disparar = 1'b1;
    step();
    m_st = S_AVA;
    chk_all("segurar_avalia");
    step();
    apply(1, 2);
    chk_all("segurar_resultado");
    e_pa = 1'b0; e_pe = 1'b0; e_pi = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_all("segurar_sem_repeticao");
    end
    disparar = 1'b0;
    step();
    chk_all("segurar_solto");
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < 5; i++) mapa[i] = 7'($urandom & $urandom);
      start_game();
      n = 0;
      while (m_st == S_JOG && n < 60) begin
        found = 1'b0;
        l = int'($urandom_range(0, 5));
        c = int'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1)
          for (int i = 0; i < 5; i++)
            for (int j = 0; j < 7; j++)
              if (!found && m_map[i][j] != 0 && !m_hit[i][j]) begin
                found = 1'b1;
                l = i;
                c = j;
              end
        fire(l, c);
        n++;
      end
      fire(0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/controle_disparo.md
Name: controle_disparo

Overview:
- Downstream consumer of the map selector. Takes the confirmed 5x7 game map on mapa0..mapa4 and runs the shooting phase of the game.
- Snapshots the map when the game starts, counts the ship cells, then accepts debounced shot requests at (linha, coluna).
- Classifies each shot as hit, miss, repeated or invalid, and keeps hit/miss matrices for the LED display stage.
- Declares victory when every ship cell has been hit, and defeat after MAX_ERROS misses.

Parameters:
MAX_ERROS, 5, number of misses that ends the game in defeat (1..15)
LINHAS, 5, map rows (fixed by map format; not meant to be overridden)
COLUNAS, 7, map columns (fixed by map format; not meant to be overridden)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
iniciar  input  1  level; sampled high starts or restarts a game
disparar  input  1  fire button level (already debounced); the block acts on its rising edge
linha  input  3  target row, valid 0..4
coluna  input  3  target column, valid 0..6; column c is bit c of the row word
mapa0..mapa4  input  7 each  confirmed map rows; 1 = ship cell
acerto0..acerto4  output  7 each  cells hit so far
erro0..erro4  output  7 each  cells missed so far
restantes  output  6  ship cells not yet hit
erros  output  4  misses so far
estado  output  3  FSM state code
pulso_acerto  output  1  one-cycle pulse on a hit
pulso_erro  output  1  one-cycle pulse on a miss
pulso_invalido  output  1  one-cycle pulse on an out-of-range or repeated shot
venceu  output  1  high while in VITORIA
perdeu  output  1  high while in DERROTA

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; estado = OCIOSO.
  - Internal map snapshot and disparar_q (previous disparar sample) cleared.
  - Reset takes effect at the next clk edge, even mid-game or mid-count.
- Edge detect: borda = disparar & ~disparar_q. disparar_q updates every cycle.
- State codes: OCIOSO=0, CONTAGEM=1, JOGANDO=2, AVALIA=3, VITORIA=4, DERROTA=5.
- iniciar sampled high, in any state:
  - Copy mapa0..4 into the snapshot; clear acerto*, erro*, restantes, erros and the row index.
  - Go to CONTAGEM.
  - iniciar has priority over borda in the same cycle.
- CONTAGEM:
  - One row per cycle, rows 0..4: restantes += popcount(snapshot row).
  - After row 4 (5 cycles), go to JOGANDO; if the total is 0, go to VITORIA instead.
  - disparar edges during CONTAGEM are ignored.
- JOGANDO: on borda, register linha/coluna and go to AVALIA.
- AVALIA (one cycle), exactly one of these, with the pulse high during the following cycle:
  - Invalid: linha>4 or coluna>6, or the cell is already set in acerto or erro. Result: pulso_invalido; no state change to matrices or counters.
  - Hit: snapshot cell = 1. Result: set the acerto cell, restantes -= 1, pulso_acerto.
  - Miss: snapshot cell = 0. Result: set the erro cell, erros += 1, pulso_erro.
  - Next state: VITORIA if restantes reaches 0; DERROTA if erros reaches MAX_ERROS; otherwise JOGANDO.
- Latency: borda seen at edge k → AVALIA after k → matrices, counters and pulse updated at edge k+1 → next shot accepted from edge k+2.
- A shot whose rising edge falls during AVALIA is lost (no queue).
- VITORIA / DERROTA:
  - Terminal; matrices and counters hold; borda is ignored.
  - Only iniciar or reset leaves them.
- OCIOSO: borda is ignored.
- mapa inputs changing after the snapshot have no effect until the next iniciar.
- restantes never underflows, because a hit requires an unhit ship cell. erros saturates at MAX_ERROS.

Decomposition:
- Package jogo_pkg:
  - state encodings;
  - LINHAS and COLUNAS;
  - popcount7 function;
  - the coordinate-valid check.
- One sub-module, detector_borda: 1-bit registered rising-edge detector with synchronous reset. It can be reused by other button inputs.
- Everything else lives in controle_disparo.

Test Plan:
- Map = {0000100, 0001100, 1000101, 1110001, 1000011}, pulse iniciar → CONTAGEM for 5 cycles, then JOGANDO with restantes=13, erros=0, all matrices 0.
- Same map, fire (0,2) → pulso_acerto 2 cycles after the edge; acerto0=0000100, restantes=12. Fire (0,2) again → pulso_invalido; nothing else changes.
- Fire (0,0), (0,1), (0,3), (0,4), (0,5) with MAX_ERROS=5 → five pulso_erro; erro0=0111011, erros=5, then DERROTA with perdeu=1. A further edge → no change.
- Fire all 13 ship cells in any order → restantes counts down to 0, then VITORIA with venceu=1. Fire (5,0) or (1,7) beforehand → pulso_invalido only.
- Map all zeros + iniciar → after 5 cycles, VITORIA with restantes=0. Assert reset during CONTAGEM, then during AVALIA → the next cycle shows estado=OCIOSO and all outputs 0.
- iniciar and disparar rising in the same cycle while JOGANDO → restart into CONTAGEM and no shot pulse. Holding disparar high for 10 cycles → exactly one shot.
